// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch stage with program RAM; IFETCH_BOUNDS_CHECK_EN adds an out-of-range fault and HALT
module ifetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 64,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [31:0]              out_instr,
  output logic [5:0]               opcode,
  output logic                     is_rtype
`ifdef IFETCH_BOUNDS_CHECK_EN
  ,
  output logic                     fault
`endif
);

  localparam int                IDX_W = $clog2(DEPTH);
  // PC_STEP is 1 or 4, so the word index is the PC shifted right by 0 or 2
  localparam int                SHIFT = (PC_STEP == 4) ? 2 : 0;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                w_load;
  logic [ADDR_W-1:0]   r_out_pc;
  logic [31:0]         r_instr;
  logic [IDX_W-1:0]    w_index;
  logic [31:0]         r_mem [DEPTH];
`ifdef IFETCH_BOUNDS_CHECK_EN
  logic                w_oob;
  logic                r_fault;
  logic                w_fault_nxt;
`endif

  // Index wraps modulo DEPTH by taking only the low index bits of the word address
  assign w_index   = r_pc[SHIFT +: IDX_W];
`ifdef IFETCH_BOUNDS_CHECK_EN
  assign w_oob     = |(r_pc >> (SHIFT + IDX_W));
  assign fault     = r_fault;
`endif
  assign out_valid = r_valid;
  assign out_pc    = r_out_pc;
  assign out_instr = r_instr;
  assign opcode    = r_instr[31:26];
  assign is_rtype  = (r_instr[31:26] == 6'b000000);

  // Next-state and datapath control: redirect beats stall, stall beats fetch
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_load      = 1'b0;
`ifdef IFETCH_BOUNDS_CHECK_EN
    w_fault_nxt = r_fault;
`endif
    case (r_state)
      IDLE: begin
        if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_valid_nxt = 1'b0;
        end
        if (en) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_valid_nxt = 1'b0;
        end else if (r_valid && !out_ready) begin
          w_pc_nxt    = r_pc;
        end else if (en) begin
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
`ifdef IFETCH_BOUNDS_CHECK_EN
          if (w_oob) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = HALT;
          end else begin
            w_pc_nxt    = r_pc + STEP;
          end
`else
          w_pc_nxt    = r_pc + STEP;
`endif
        end else begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      HALT: begin
        if (r_valid && out_ready) begin
          w_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC and output bundle; the RAM read here sees the pre-write word on a same-cycle write
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_out_pc <= '0;
      r_instr  <= '0;
`ifdef IFETCH_BOUNDS_CHECK_EN
      r_fault  <= 1'b0;
`endif
    end else begin
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
`ifdef IFETCH_BOUNDS_CHECK_EN
      r_fault <= w_fault_nxt;
`endif
      if (w_load) begin
        r_out_pc <= r_pc;
`ifdef IFETCH_BOUNDS_CHECK_EN
        r_instr  <= w_oob ? 32'h0000_0000 : r_mem[w_index];
`else
        r_instr  <= r_mem[w_index];
`endif
      end
    end
  end

  // Program-load port; contents survive reset
  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - directed self-checking bench for ifetch_stage
module tb_ifetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // main instance: ADDR_W=32, DEPTH=64, PC_STEP=4, RESET_PC=0
  logic        m_en, m_redirect, m_prog_we, m_ready, m_valid, m_rtype;
  logic [31:0] m_redirect_pc, m_prog_data, m_pc, m_instr;
  logic [5:0]  m_prog_addr, m_opcode;

  // wrap instance: ADDR_W=8, RESET_PC=0xFC
  logic        x_en, x_redirect, x_prog_we, x_ready, x_valid, x_rtype;
  logic [7:0]  x_redirect_pc, x_pc;
  logic [31:0] x_prog_data, x_instr;
  logic [5:0]  x_prog_addr, x_opcode;

  // small instance: DEPTH=4
  logic        s_en, s_redirect, s_prog_we, s_ready, s_valid, s_rtype;
  logic [31:0] s_redirect_pc, s_prog_data, s_pc, s_instr;
  logic [1:0]  s_prog_addr;
  logic [5:0]  s_opcode;

`ifdef IFETCH_BOUNDS_CHECK_EN
  logic m_fault, x_fault, s_fault;
`endif

  ifetch_stage #(.ADDR_W(32), .DEPTH(64), .PC_STEP(4), .RESET_PC(32'h0)) u_main (
    .clk(clk), .reset(reset), .en(m_en), .redirect(m_redirect), .redirect_pc(m_redirect_pc),
    .prog_we(m_prog_we), .prog_addr(m_prog_addr), .prog_data(m_prog_data), .out_ready(m_ready),
    .out_valid(m_valid), .out_pc(m_pc), .out_instr(m_instr), .opcode(m_opcode), .is_rtype(m_rtype)
`ifdef IFETCH_BOUNDS_CHECK_EN
    , .fault(m_fault)
`endif
  );

  ifetch_stage #(.ADDR_W(8), .DEPTH(64), .PC_STEP(4), .RESET_PC(8'hFC)) u_wrap (
    .clk(clk), .reset(reset), .en(x_en), .redirect(x_redirect), .redirect_pc(x_redirect_pc),
    .prog_we(x_prog_we), .prog_addr(x_prog_addr), .prog_data(x_prog_data), .out_ready(x_ready),
    .out_valid(x_valid), .out_pc(x_pc), .out_instr(x_instr), .opcode(x_opcode), .is_rtype(x_rtype)
`ifdef IFETCH_BOUNDS_CHECK_EN
    , .fault(x_fault)
`endif
  );

  ifetch_stage #(.ADDR_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'h0)) u_small (
    .clk(clk), .reset(reset), .en(s_en), .redirect(s_redirect), .redirect_pc(s_redirect_pc),
    .prog_we(s_prog_we), .prog_addr(s_prog_addr), .prog_data(s_prog_data), .out_ready(s_ready),
    .out_valid(s_valid), .out_pc(s_pc), .out_instr(s_instr), .opcode(s_opcode), .is_rtype(s_rtype)
`ifdef IFETCH_BOUNDS_CHECK_EN
    , .fault(s_fault)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int sel, input string tag);
    logic v;
    v = 1'b0;
    for (int i = 0; i < 8 && !v; i++) begin
      tick();
      v = (sel == 0) ? m_valid : (sel == 1) ? x_valid : s_valid;
    end
    chk(tag, 64'(v), 64'd1);
  endtask

  function automatic logic [31:0] memw(input int i);
    if (i == 0)      return 32'h0022_1820;
    else if (i == 1) return 32'h2109_000A;
    else             return 32'h1000_0000 + 32'(i);
  endfunction

  initial begin
    reset = 1'b0;
    m_en = 0; m_redirect = 0; m_redirect_pc = '0; m_prog_we = 0; m_prog_addr = '0; m_prog_data = '0; m_ready = 0;
    x_en = 0; x_redirect = 0; x_redirect_pc = '0; x_prog_we = 0; x_prog_addr = '0; x_prog_data = '0; x_ready = 0;
    s_en = 0; s_redirect = 0; s_redirect_pc = '0; s_prog_we = 0; s_prog_addr = '0; s_prog_data = '0; s_ready = 0;
    tick();

    // program load while held in reset
    for (int i = 0; i < 32; i++) begin
      m_prog_we   = 1'b1;
      m_prog_addr = 6'(i);
      m_prog_data = memw(i);
      s_prog_we   = (i < 4);
      s_prog_addr = 2'(i);
      s_prog_data = 32'(32'h1111_1111 * (i + 1));
      tick();
    end
    m_prog_we = 1'b0;
    s_prog_we = 1'b0;

    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_pc",    64'(m_pc),    64'd0);
    chk("rst_instr", 64'(m_instr), 64'd0);

    // basic fetch
    reset = 1'b1; m_en = 1'b1; m_ready = 1'b1;
    wait_valid(0, "start_valid");
    chk("f0_pc",    64'(m_pc),    64'd0);
    chk("f0_instr", 64'(m_instr), 64'h0022_1820);
    chk("f0_rtype", 64'(m_rtype), 64'd1);
    tick();
    chk("f1_pc",     64'(m_pc),     64'd4);
    chk("f1_instr",  64'(m_instr),  64'h2109_000A);
    chk("f1_opcode", 64'(m_opcode), 64'(6'b001000));
    chk("f1_rtype",  64'(m_rtype),  64'd0);
    tick();
    chk("f2_pc",    64'(m_pc),    64'd8);
    chk("f2_instr", 64'(m_instr), 64'(memw(2)));

    // three-cycle stall
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", 64'(m_valid), 64'd1);
      chk("stall_pc",    64'(m_pc),    64'd8);
      chk("stall_instr", 64'(m_instr), 64'(memw(2)));
    end
    m_ready = 1'b1;
    tick();
    chk("resume_pc",    64'(m_pc),    64'd12);
    chk("resume_instr", 64'(m_instr), 64'(memw(3)));

    // redirect during a stall
    m_ready = 1'b0;
    tick();
    chk("pre_redir_pc", 64'(m_pc), 64'd12);
    m_redirect = 1'b1; m_redirect_pc = 32'h40;
    tick();
    m_redirect = 1'b0;
    chk("redir_flush", 64'(m_valid), 64'd0);
    tick();
    chk("redir_valid", 64'(m_valid), 64'd1);
    chk("redir_pc",    64'(m_pc),    64'h40);
    chk("redir_instr", 64'(m_instr), 64'(memw(16)));

    // same-cycle write and fetch of word 17 returns the old word
    m_ready = 1'b1;
    m_prog_we = 1'b1; m_prog_addr = 6'd17; m_prog_data = 32'hDEAD_BEEF;
    tick();
    m_prog_we = 1'b0;
    chk("rw_pc",    64'(m_pc),    64'h44);
    chk("rw_instr", 64'(m_instr), 64'(memw(17)));
    m_redirect = 1'b1; m_redirect_pc = 32'h44;
    tick();
    m_redirect = 1'b0;
    chk("rw_flush", 64'(m_valid), 64'd0);
    tick();
    chk("rw_new_pc",    64'(m_pc),    64'h44);
    chk("rw_new_instr", 64'(m_instr), 64'hDEAD_BEEF);

    // en=0 on a free slot drops valid and holds pc
    m_en = 1'b0;
    tick();
    chk("en0_valid", 64'(m_valid), 64'd0);
    tick();
    chk("idle_valid", 64'(m_valid), 64'd0);
    m_en = 1'b1;
    wait_valid(0, "reen_valid");
    chk("reen_pc",    64'(m_pc),    64'h48);
    chk("reen_instr", 64'(m_instr), 64'(memw(18)));

    // reset while stalled, with a redirect pending
    m_ready = 1'b0;
    tick();
    chk("pre_rst_pc", 64'(m_pc), 64'h48);
    reset = 1'b0; m_redirect = 1'b1; m_redirect_pc = 32'h80;
    tick();
    m_redirect = 1'b0;
    chk("mrst_valid", 64'(m_valid), 64'd0);
    chk("mrst_pc",    64'(m_pc),    64'd0);
    chk("mrst_instr", 64'(m_instr), 64'd0);
    reset = 1'b1; m_ready = 1'b1;
    wait_valid(0, "rerun_valid");
    chk("rerun_pc",    64'(m_pc),    64'd0);
    chk("rerun_instr", 64'(m_instr), 64'h0022_1820);
    tick();
    chk("rerun_instr1", 64'(m_instr), 64'h2109_000A);
    m_en = 1'b0;

    // PC wrap with ADDR_W=8
    x_en = 1'b1; x_ready = 1'b1;
    wait_valid(1, "wrap_valid");
    chk("wrap_pc0", 64'(x_pc), 64'hFC);
    tick();
    chk("wrap_pc1", 64'(x_pc), 64'h00);
    tick();
    chk("wrap_pc2", 64'(x_pc), 64'h04);
    x_en = 1'b0;

    // DEPTH=4: fetch at pc=16
    s_en = 1'b1; s_ready = 1'b1;
    wait_valid(2, "small_valid");
    chk("small_pc0",    64'(s_pc),    64'd0);
    chk("small_instr0", 64'(s_instr), 64'h1111_1111);
    tick(); tick(); tick();
    chk("small_pc3",    64'(s_pc),    64'd12);
    chk("small_instr3", 64'(s_instr), 64'h4444_4444);
    tick();
    chk("small_pc4", 64'(s_pc), 64'd16);
`ifdef IFETCH_BOUNDS_CHECK_EN
    chk("oob_instr", 64'(s_instr), 64'd0);
    chk("oob_valid", 64'(s_valid), 64'd1);
    chk("oob_fault", 64'(s_fault), 64'd1);
    tick();
    chk("halt_valid", 64'(s_valid), 64'd0);
    chk("halt_fault", 64'(s_fault), 64'd1);
    tick();
    chk("halt_stay", 64'(s_valid), 64'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("fault_clr", 64'(s_fault), 64'd0);
`else
    chk("wrap_idx_instr", 64'(s_instr), 64'h1111_1111);
    tick();
    chk("small_pc5",    64'(s_pc),    64'd20);
    chk("small_instr5", 64'(s_instr), 64'h2222_2222);
`endif
    s_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, instruction words in memory; power of 2, >=2.
REQ-003 SHALL have parameter PC_STEP, default 4, PC increment per fetch; legal values 1 (word-addressed) or 4 (byte-addressed).
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have port en  in  1  fetch enable; starts and keeps fetching.
REQ-008 SHALL have port redirect  in  1  branch/jump request; one-cycle pulse.
REQ-009 SHALL have port redirect_pc  in  ADDR_W  redirect target.
REQ-010 SHALL have port prog_we  in  1  program-load write enable.
REQ-011 SHALL have port prog_addr  in  $clog2(DEPTH)  program-load word index.
REQ-012 SHALL have port prog_data  in  32  program-load word.
REQ-013 SHALL have port out_ready  in  1  downstream accepts the current output.
REQ-014 SHALL have port out_valid  out  1  output bundle holds a fetched instruction.
REQ-015 SHALL have port out_pc  out  ADDR_W  PC of the fetched instruction.
REQ-016 SHALL have port out_instr  out  32  fetched instruction word.
REQ-017 SHALL have port opcode  out  6  out_instr[31:26].
REQ-018 SHALL have port is_rtype  out  1  high when opcode == 6'b000000; combinational from out_instr.
REQ-019 SHALL have port fault  out  1  out-of-range fetch flag; present only with IFETCH_BOUNDS_CHECK_EN.

Function
REQ-020 SHALL implement the FSM states IDLE, RUN and HALT.
REQ-021 IDLE -> RUN when en=1; RUN -> IDLE when en=0 and no transfer is pending; HALT exits only on reset.
REQ-022 SHALL map memory word index as (pc / PC_STEP) mod DEPTH.
REQ-023 SHALL treat a fetch slot as free in RUN when out_valid=0 or out_ready=1.
REQ-024 On a free fetch slot, next edge SHALL load: out_instr=mem[index]; out_pc=pc; out_valid=1; pc=pc+PC_STEP (1-cycle latency).
REQ-025 SHALL increment pc modulo 2^ADDR_W; 2^ADDR_W-PC_STEP wraps to 0.
REQ-026 When out_valid=1 and out_ready=0 (stall), out_pc, out_instr and pc SHALL hold unchanged.
REQ-027 On a free slot with en=0, out_valid SHALL go 0 and pc SHALL hold.
REQ-028 redirect SHALL take priority over stall and fetch: next edge pc=redirect_pc, out_valid=0 (flush), and the fetch at redirect_pc SHALL appear one cycle later.
REQ-029 prog_we SHALL write mem[prog_addr] at the edge in any state.
REQ-030 A write and a fetch of the same word in one cycle SHALL return the old word.
REQ-031 Memory contents SHALL be unaffected by reset.

Reset
REQ-032 With reset=0 at an edge: state=IDLE, pc=RESET_PC, out_valid=0, out_pc=0, out_instr=0, fault=0.
REQ-033 Reset mid-operation SHALL discard any held or stalled output and any pending redirect.

Configuration
REQ-034 Macro IFETCH_BOUNDS_CHECK_EN defined: a fetch with pc/PC_STEP >= DEPTH SHALL load out_instr=0 (NOP) with out_valid=1, set fault=1 sticky, and enter HALT (out_valid drops after acceptance).
REQ-035 Macro IFETCH_BOUNDS_CHECK_EN undefined: the fault port is absent, the index wraps modulo DEPTH (REQ-022), and HALT is unreachable.

Verification
REQ-036 Load mem[0]=0x00221820, mem[1]=0x2109000A; PC_STEP=4; en=1; out_ready=1 -> cycle 1: out_pc=0, out_instr=0x00221820, is_rtype=1; cycle 2: out_pc=4, out_instr=0x2109000A, opcode=001000, is_rtype=0.
REQ-037 out_ready=0 for 3 cycles while out_pc=8 -> out_pc=8 and out_instr stable for all 3 cycles; out_pc=12 appears 1 cycle after out_ready=1.
REQ-038 redirect=1, redirect_pc=0x40 during a stall -> next cycle out_valid=0; the following cycle out_pc=0x40 with instr=mem[16].
REQ-039 RESET_PC=2^ADDR_W-4, ADDR_W=8 -> out_pc sequence 0xFC, 0x00, 0x04.
REQ-040 With IFETCH_BOUNDS_CHECK_EN: DEPTH=4, run to pc=16 -> out_instr=0, fault=1, state HALT; reset=0 clears fault. Without the macro: out_instr=mem[0].
REQ-041 reset=0 asserted while out_valid=1 and stalled -> next cycle out_valid=0, pc=RESET_PC, and loaded memory is intact on re-run.
